// File: rtl/seq_addsub_chunked.sv
// seq_addsub_chunked: chunk-serial add/subtract with registered carry ripple and full-width result.
// Optional signed-overflow flag built only when SEQ_ADDSUB_OVF_EN is defined.
module seq_addsub_chunked #(
    parameter int TOTAL_W = 48,
    parameter int CHUNK_W = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               sub_mode,
    input  logic               chunk_valid,
    input  logic [CHUNK_W-1:0] in_a,
    input  logic [CHUNK_W-1:0] in_b,
    output logic               busy,
    output logic               result_ready,
    output logic [TOTAL_W-1:0] out_bus,
    output logic               carry_out,
    output logic               ovf
);
    localparam int NUM_CHUNKS = TOTAL_W / CHUNK_W;
    localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    if (TOTAL_W % CHUNK_W != 0) begin : g_bad_div
        $error("TOTAL_W must be an exact multiple of CHUNK_W");
    end
    if (NUM_CHUNKS < 2) begin : g_bad_num
        $error("NUM_CHUNKS must be at least 2");
    end

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               sub_q, sub_d;
    logic [TOTAL_W-1:0] work_q, work_d;
    logic [TOTAL_W-1:0] out_q, out_d;
    logic               cout_q, cout_d;
    logic [CHUNK_W-1:0] b_eff;
    logic [CHUNK_W:0]   sum;
    logic               last_beat;

    assign b_eff     = sub_q ? ~in_b : in_b;
    assign sum       = {1'b0, in_a} + {1'b0, b_eff} + (CHUNK_W + 1)'(carry_q);
    assign last_beat = (state_q == ACCUM) && chunk_valid && (idx_q == LAST_IDX);

    assign busy         = (state_q == ACCUM);
    assign result_ready = (state_q == DONE);
    assign out_bus      = out_q;
    assign carry_out    = cout_q;

    // State and datapath registers; the published result is loaded on the last-chunk edge so it is valid alongside result_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            work_q  <= '0;
            out_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            work_q  <= work_d;
            out_q   <= out_d;
            cout_q  <= cout_d;
        end
    end

    // Next-state: accept start only in IDLE, consume valid chunks in ACCUM, spend one cycle in DONE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        work_d  = work_q;
        out_d   = out_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sub_d   = sub_mode;
                    carry_d = sub_mode;
                    idx_d   = '0;
                    work_d  = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (chunk_valid) begin
                    work_d[int'(idx_q) * CHUNK_W +: CHUNK_W] = sum[CHUNK_W-1:0];
                    carry_d = sum[CHUNK_W];
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        out_d   = work_d;
                        cout_d  = sum[CHUNK_W];
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef SEQ_ADDSUB_OVF_EN
    logic ovf_q, ovf_d;
    logic cin_msb;

    assign cin_msb = in_a[CHUNK_W-1] ^ b_eff[CHUNK_W-1] ^ sum[CHUNK_W-1];
    assign ovf_d   = last_beat ? (cin_msb ^ sum[CHUNK_W]) : ovf_q;
    assign ovf     = ovf_q;

    // Overflow flag captured from the top chunk and held with the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end
`else
    logic unused_last;
    assign unused_last = last_beat;
    assign ovf = 1'b0;
`endif
endmodule
